// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared constants and state encoding for the systolic input feed controller.
package systolic_feed_ctrl_pkg;

   localparam int FEED_ADDR_WIDTH   = 10;
   localparam int FEED_DATA_WIDTH   = 64;
   localparam int FEED_LANES        = 8;
   localparam int FEED_DRAIN_CYCLES = FEED_LANES - 1;

   typedef enum logic [1:0] {
      FEED_IDLE   = 2'd0,
      FEED_STREAM = 2'd1,
      FEED_DRAIN  = 2'd2,
      FEED_DONE   = 2'd3
   } feed_state_t;

endpackage

// File: rtl/systolic_feed_ctrl.sv
// Streams a contiguous run of BRAM words into the skew stage, then appends
// zero words to flush the skew pipeline and pulses done_o.
//
// Flow control: the skew stage accepts word_o whenever en_o is high; there is
// no ready. stall_i in cycle c blocks both the BRAM read and the transfer in
// c, so en_o is low in c+1 and word_o keeps its last value. Because no read is
// issued during a stall, bram_dout_i holds the pending word and nothing is
// lost or duplicated.
module systolic_feed_ctrl
   import systolic_feed_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH   = FEED_ADDR_WIDTH,
   parameter int DATA_WIDTH   = FEED_DATA_WIDTH,
   parameter int LANES        = FEED_LANES,
   parameter int DRAIN_CYCLES = LANES - 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   num_words_i,
   input  logic                  stall_i,
   output logic                  bram_en_o,
   output logic [ADDR_WIDTH-1:0] bram_addr_o,
   input  logic [DATA_WIDTH-1:0] bram_dout_i,
   output logic [DATA_WIDTH-1:0] word_o,
   output logic                  en_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int CNT_W   = ADDR_WIDTH + 1;
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

   // state is left as a plain named signal so checkers can bind to it
   feed_state_t           state;
   feed_state_t           state_nxt;
   logic [ADDR_WIDTH-1:0] base;
   logic [CNT_W-1:0]      num;
   logic [CNT_W-1:0]      issued;
   logic [CNT_W-1:0]      received;
   logic [DRAIN_W-1:0]    drain_cnt;
   logic                  rd_pending;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  accept;
   logic                  issue;
   logic                  transfer;
   logic                  drain_emit;

   // Next state and per-cycle issue/transfer/drain decisions.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      issue      = 1'b0;
      transfer   = 1'b0;
      drain_emit = 1'b0;
      case (state)
         FEED_IDLE: begin
            if (start_i) begin
               accept    = 1'b1;
               state_nxt = (num_words_i == '0) ? FEED_DONE : FEED_STREAM;
            end
         end
         FEED_STREAM: begin
            issue    = (issued < num) && !stall_i;
            transfer = rd_pending && !stall_i;
            if (transfer && (received + 1'b1 == num)) begin
               state_nxt = FEED_DRAIN;
            end
         end
         FEED_DRAIN: begin
            // The cycle after the last zero word is spent here so that en_o
            // is already low when done_o is raised.
            if (!stall_i) begin
               if (drain_cnt == DRAIN_W'(DRAIN_CYCLES)) begin
                  state_nxt = FEED_DONE;
               end else begin
                  drain_emit = 1'b1;
               end
            end
         end
         FEED_DONE: begin
            state_nxt = FEED_IDLE;
         end
         default: begin
            state_nxt = FEED_IDLE;
         end
      endcase
   end

   // Address wraps naturally at 2^ADDR_WIDTH; it holds between reads.
   assign bram_en_o   = issue;
   assign bram_addr_o = issue ? (base + issued[ADDR_WIDTH-1:0]) : addr_q;
   assign busy_o      = (state == FEED_STREAM) || (state == FEED_DRAIN);
   assign done_o      = (state == FEED_DONE);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= FEED_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Run parameters, counters and the registered skew-stage outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         base       <= '0;
         num        <= '0;
         issued     <= '0;
         received   <= '0;
         drain_cnt  <= '0;
         rd_pending <= 1'b0;
         addr_q     <= '0;
         word_o     <= '0;
         en_o       <= 1'b0;
      end else begin
         en_o <= transfer || drain_emit;
         if (transfer) begin
            word_o <= bram_dout_i;
         end else if (drain_emit) begin
            word_o <= '0;
         end
         if (accept) begin
            base       <= base_addr_i;
            num        <= num_words_i;
            issued     <= '0;
            received   <= '0;
            drain_cnt  <= '0;
            rd_pending <= 1'b0;
         end
         if (issue) begin
            issued     <= issued + 1'b1;
            addr_q     <= bram_addr_o;
            rd_pending <= 1'b1;
         end else if (transfer) begin
            rd_pending <= 1'b0;
         end
         if (transfer) begin
            received <= received + 1'b1;
         end
         if (drain_emit) begin
            drain_cnt <= drain_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl with a BRAM model (mem[k] = k+1)
// and an expected-word queue checked on every en_o cycle.
module tb_systolic_feed_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  base;
   logic [10:0] num;
   logic        stall;
   logic        bram_en;
   logic [9:0]  bram_addr;
   logic [63:0] bram_dout;
   logic [63:0] word;
   logic        en;
   logic        busy;
   logic        done;

   logic [63:0] mem [0:1023];
   logic [63:0] exp_q [$];
   logic [9:0]  addr_log [$];
   int          total = 0;
   int          bad = 0;
   int          en_cnt = 0;
   int          rd_cnt = 0;
   int          done_cnt = 0;
   int          cyc = 0;
   int          first_en_cyc = 0;
   int          first_rd_cyc = 0;

   systolic_feed_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .base_addr_i (base),
      .num_words_i (num),
      .stall_i     (stall),
      .bram_en_o   (bram_en),
      .bram_addr_o (bram_addr),
      .bram_dout_i (bram_dout),
      .word_o      (word),
      .en_o        (en),
      .busy_o      (busy),
      .done_o      (done)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      for (int k = 0; k < 1024; k++) mem[k] = 64'(k + 1);
      bram_dout = '0;
   end

   // synchronous BRAM, one-cycle read latency, output held when not enabled
   always @(posedge clk) begin
      if (bram_en) bram_dout <= mem[bram_addr];
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard / monitor, sampled on the falling edge
   initial forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
         if (bram_en) begin
            if (rd_cnt == 0) first_rd_cyc = cyc;
            addr_log.push_back(bram_addr);
            rd_cnt++;
         end
         if (en) begin
            if (en_cnt == 0) first_en_cyc = cyc;
            en_cnt++;
            if (exp_q.size() == 0) check("word_unexpected", {63'd0, en}, 64'd0);
            else check("word", word, exp_q.pop_front());
         end
         if (done) done_cnt++;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_words(input logic [9:0] b, input int n);
      logic [9:0] a;
      for (int i = 0; i < n; i++) begin
         a = b + 10'(i);
         exp_q.push_back(mem[a]);
      end
      for (int i = 0; i < 7; i++) exp_q.push_back(64'd0);
   endtask

   task automatic start_op(input logic [9:0] b, input logic [10:0] n);
      en_cnt   = 0;
      rd_cnt   = 0;
      done_cnt = 0;
      addr_log.delete();
      tick();
      start = 1'b1;
      base  = b;
      num   = n;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int lat = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (done === 1'b1) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
         check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
         check({tag, "_en_at_done"}, 64'(en), 64'd0);
         tick();
         @(negedge clk);
         check({tag, "_done_width"}, 64'(done), 64'd0);
      end
   endtask

   task automatic end_checks(input string tag, input int exp_en, input int exp_rd);
      check({tag, "_en_count"}, 64'(en_cnt), 64'(exp_en));
      check({tag, "_rd_count"}, 64'(rd_cnt), 64'(exp_rd));
      check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      check({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_addrs(input string tag, input logic [9:0] b, input int n);
      logic [9:0] a;
      check({tag, "_addr_count"}, 64'(addr_log.size()), 64'(n));
      for (int i = 0; i < n && i < addr_log.size(); i++) begin
         a = b + 10'(i);
         check({tag, "_addr"}, 64'(addr_log[i]), 64'(a));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_en"}, 64'(en), 64'd0);
      check({tag, "_word"}, word, 64'd0);
      check({tag, "_bram_en"}, 64'(bram_en), 64'd0);
      check({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      base  = '0;
      num   = '0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      tick();
      rst = 1'b0;

      // basic stream
      expect_words(10'd0, 8);
      start_op(10'd0, 11'd8);
      wait_done("basic", 18);
      end_checks("basic", 15, 8);
      check_addrs("basic", 10'd0, 8);
      check("basic_first_latency", 64'(first_en_cyc - first_rd_cyc), 64'd2);

      // stall for three cycles while the 4th word (mem[19]) is on word_o
      expect_words(10'd16, 16);
      start_op(10'd16, 11'd16);
      repeat (5) tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) stall = 1'b0;
         @(negedge clk);
         check("stall_en_low", 64'(en), 64'd0);
         check("stall_word_held", word, 64'd20);
      end
      wait_done("stall", 20);
      end_checks("stall", 23, 16);
      check_addrs("stall", 10'd16, 16);

      // address wrap
      expect_words(10'd1022, 4);
      start_op(10'd1022, 11'd4);
      wait_done("wrap", 14);
      end_checks("wrap", 11, 4);
      check_addrs("wrap", 10'd1022, 4);

      // zero-length run
      start_op(10'd5, 11'd0);
      wait_done("zero", 1);
      end_checks("zero", 0, 0);

      // reset during the 5th transfer
      expect_words(10'd0, 8);
      start_op(10'd0, 11'd8);
      repeat (5) tick();
      rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      check("midrst_words_before", 64'(en_cnt), 64'd3);
      exp_q.delete();
      tick();
      rst = 1'b0;
      repeat (20) tick();
      check("midrst_no_done", 64'(done_cnt), 64'd0);
      check("midrst_no_words", 64'(en_cnt), 64'd3);
      expect_words(10'd0, 2);
      start_op(10'd0, 11'd2);
      wait_done("after_rst", 12);
      end_checks("after_rst", 9, 2);
      check_addrs("after_rst", 10'd0, 2);

      // start pulses while streaming and in the DONE cycle are ignored
      expect_words(10'd100, 8);
      start_op(10'd100, 11'd8);
      repeat (2) tick();
      start = 1'b1;
      base  = 10'd0;
      num   = 11'd3;
      tick();
      start = 1'b0;
      repeat (14) tick();
      start = 1'b1;
      @(negedge clk);
      check("busy_done_cycle", 64'(done), 64'd1);
      tick();
      start = 1'b0;
      repeat (10) tick();
      end_checks("busy", 15, 8);
      check_addrs("busy", 10'd100, 8);
      check("busy_idle_after", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
